// File: rtl/parking_input_frontend.sv
// Input conditioning for the parking gate: synchronised, debounced vehicle sensors
// and a two-digit keypad assembler that presents each completed code for a bounded window.
module parking_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ENTRY_TIMEOUT   = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       front_raw,
    input  logic       back_raw,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       key_clear,
    output logic       Front_Sensor,
    output logic       Back_Sensor,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pass_ready,
    output logic [1:0] entry_state,
    output logic [1:0] pending_digit
);

    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] ENTRY_LAST = 8'(ENTRY_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_EMPTY     = 2'd0;
    localparam logic [1:0] ST_ONE_DIGIT = 2'd1;
    localparam logic [1:0] ST_FULL      = 2'd2;

    // ------------------------------------------------------------------
    // Sensor path: bit 0 is the front sensor, bit 1 the back sensor.
    // ------------------------------------------------------------------
    logic [1:0]      raw_in;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      sens_out;
    logic [1:0][7:0] deb_cnt;

    assign raw_in = {back_raw, front_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sens_out <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            // A level must disagree with the output for DEBOUNCE_CYCLES
            // consecutive cycles before the output follows it.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == sens_out[i]) begin
                    deb_cnt[i] <= 8'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    sens_out[i] <= sync2[i];
                    deb_cnt[i]  <= 8'd0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign Front_Sensor = sens_out[0];
    assign Back_Sensor  = sens_out[1];

    // ------------------------------------------------------------------
    // Keypad entry. There is no valid/ready handshake anywhere here:
    // key_valid is a one-cycle strobe per key press that is always
    // accepted, and the assembled pair is offered downstream without
    // backpressure for HOLD_CYCLES cycles, marked by one pass_ready pulse.
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] pending;
    logic [7:0] timer;

    always_ff @(posedge clk) begin
        if (reset || key_clear) begin
            state      <= ST_EMPTY;
            pending    <= 2'b00;
            timer      <= 8'd0;
            password_1 <= 2'b00;
            password_2 <= 2'b00;
            pass_ready <= 1'b0;
        end else begin
            pass_ready <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (key_valid) begin
                        pending <= key_digit;
                        state   <= ST_ONE_DIGIT;
                        timer   <= 8'd0;
                    end
                end

                ST_ONE_DIGIT: begin
                    if (key_valid) begin
                        password_1 <= pending;
                        password_2 <= key_digit;
                        pass_ready <= 1'b1;
                        pending    <= 2'b00;
                        state      <= ST_FULL;
                        timer      <= 8'd0;
                    end else if (timer == ENTRY_LAST) begin
                        pending <= 2'b00;
                        state   <= ST_EMPTY;
                        timer   <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                ST_FULL: begin
                    // A new key during the hold window starts the next entry
                    // and withdraws the displayed pair immediately.
                    if (key_valid) begin
                        password_1 <= 2'b00;
                        password_2 <= 2'b00;
                        pending    <= key_digit;
                        state      <= ST_ONE_DIGIT;
                        timer      <= 8'd0;
                    end else if (timer == HOLD_LAST) begin
                        password_1 <= 2'b00;
                        password_2 <= 2'b00;
                        state      <= ST_EMPTY;
                        timer      <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                default: begin
                    password_1 <= 2'b00;
                    password_2 <= 2'b00;
                    pending    <= 2'b00;
                    state      <= ST_EMPTY;
                    timer      <= 8'd0;
                end
            endcase
        end
    end

    assign entry_state   = state;
    assign pending_digit = pending;

endmodule
